// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared state encoding and constants for the fetch sequencer
package pc_fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, EXEC} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0100;
endpackage

// File: rtl/instret_counter.sv
// instret_counter: 64-bit retired-instruction counter with sync clear and enable
module instret_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [63:0] count
);
  logic [63:0] count_q, count_d;
  always_comb count_d = en ? count_q + 64'd1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? 64'd0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and valid/ready instruction-fetch sequencer
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = PC_WIDTH'(DEF_TRAP_VECTOR)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc_plus_4,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                stall,
  output logic                imem_req_valid,
  output logic [PC_WIDTH-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [31:0]         imem_rsp_data,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                misalign_trap,
  output logic [63:0]         instret
);
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                trap_q, trap_d, commit, misaligned;
  always_comb begin
    commit = state_q == EXEC && !stall;
    misaligned = redirect_target[1:0] != 2'b00;
    state_d = state_q == IDLE ? REQ :
              state_q == REQ  ? (imem_req_ready ? WAIT : REQ) :
              state_q == WAIT ? (imem_rsp_valid ? EXEC : WAIT) :
              (stall ? EXEC : REQ);
    pc_d = !commit ? pc_q : !redirect_valid ? pc_plus_4 : misaligned ? TRAP_VECTOR : redirect_target;
    instr_d = state_q == WAIT && imem_rsp_valid ? imem_rsp_data : instr_q;
    trap_d = commit && redirect_valid && misaligned;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      trap_q  <= trap_d;
    end
  end
  instret_counter u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (commit),
    .count (instret)
  );
  assign imem_req_valid = state_q == REQ;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = state_q == EXEC;
  assign misalign_trap  = trap_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and model-checked bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_plus_4;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misalign_trap;
  logic [63:0] instret;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] addr_q[$];
  pc_fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_plus_4(pc_plus_4),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .stall(stall),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .misalign_trap(misalign_trap), .instret(instret)
  );
  assign pc_plus_4 = pc + 32'd4;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  typedef enum {M_IDLE, M_REQ, M_WAIT, M_EXEC} phase_t;
  phase_t      mph = M_IDLE;
  logic        mvalid = 1'b0;
  logic [31:0] mpc = '0;
  logic [31:0] minstr = '0;
  logic [63:0] mret = '0;
  logic        mtrap = 1'b0;
  always @(posedge clk) begin
    if (rst) begin
      mvalid <= 1'b1;
      mph <= M_IDLE;
      mpc <= 32'h0;
      minstr <= 32'h13;
      mret <= '0;
      mtrap <= 1'b0;
    end else begin
      mtrap <= 1'b0;
      if (mph == M_IDLE) mph <= M_REQ;
      else if (mph == M_REQ) begin
        if (imem_req_ready) mph <= M_WAIT;
      end else if (mph == M_WAIT) begin
        if (imem_rsp_valid) begin
          minstr <= imem_rsp_data;
          mph <= M_EXEC;
        end
      end else if (!stall) begin
        mret <= mret + 64'd1;
        mph <= M_REQ;
        if (!redirect_valid) mpc <= mpc + 32'd4;
        else if (redirect_target % 4 != 0) begin
          mpc <= 32'h100;
          mtrap <= 1'b1;
        end else mpc <= redirect_target;
      end
    end
  end
  always @(posedge clk)
    if (!rst && imem_req_valid && imem_req_ready) addr_q.push_back(imem_req_addr);
  always @(negedge clk)
    if (mvalid) begin
      chk("m_pc", pc, mpc);
      chk("m_req_valid", imem_req_valid, mph == M_REQ);
      chk("m_req_addr", imem_req_addr, mpc);
      chk("m_instr", instr, minstr);
      chk("m_instr_valid", instr_valid, mph == M_EXEC);
      chk("m_trap", misalign_trap, mtrap);
      chk("m_instret", instret, mret);
    end
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    addr_q.delete();
  endtask
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00100093;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_instret", instret, 64'd0);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_instr_valid", instr_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      imem_rsp_data = 32'h00100093 + 32'(i) * 32'h100;
      cyc();
    end
    chk("seq_instret", instret, 64'd3);
    chk("seq_pc", pc, 32'hC);
    chk("seq_nreq", addr_q.size(), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("seq_addr", addr_q.size() > i ? addr_q[i] : 32'hFFFF_FFFF, 32'(4 * i));
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    do_reset();
    cyc();
    chk("ws_req_valid", imem_req_valid, 1'b1);
    chk("ws_addr", imem_req_addr, 32'h0);
    cyc();
    cyc();
    chk("ws_addr_hold", imem_req_addr, 32'h0);
    chk("ws_req_hold", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    cyc();
    cyc();
    chk("ws_no_commit", instret, 64'd0);
    chk("ws_no_exec", instr_valid, 1'b0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h02A00513;
    cyc();
    imem_rsp_valid = 1'b0;
    chk("ws_instr", instr, 32'h02A00513);
    chk("ws_exec", instr_valid, 1'b1);
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("st_pc", pc, 32'h0);
      chk("st_instret", instret, 64'd0);
      chk("st_instr", instr, 32'h02A00513);
    end
    stall = 1'b0;
    cyc();
    redirect_valid = 1'b0;
    chk("st_pc_new", pc, 32'h40);
    chk("st_req_addr", imem_req_addr, 32'h40);
    chk("st_instret_new", instret, 64'd1);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("st_hs_addr", addr_q.size() > 1 ? addr_q[1] : 32'hFFFF_FFFF, 32'h40);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'h00000067;
    cyc();
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b1;
    redirect_target = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    chk("mis_pc", pc, 32'h100);
    chk("mis_trap", misalign_trap, 1'b1);
    chk("mis_instret", instret, 64'd2);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("mis_trap_off", misalign_trap, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    addr_q.delete();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hBAD0_0BAD;
    cyc();
    imem_rsp_valid = 1'b0;
    chk("rw_instr", instr, 32'h13);
    chk("rw_instr_valid", instr_valid, 1'b0);
    chk("rw_pc", pc, 32'h0);
    chk("rw_req_addr", imem_req_addr, 32'h0);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    chk("rw_hs_addr", addr_q.size() > 0 ? addr_q[addr_q.size() - 1] : 32'hFFFF_FFFF, 32'h0);
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h80;
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hFFFF_FFFF;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk("ign_idle_pc", pc, 32'h0);
    chk("ign_idle_instr", instr, 32'h13);
    cyc();
    chk("ign_req_pc", pc, 32'h0);
    chk("ign_req_instr", instr, 32'h13);
    for (int i = 0; i < 60; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data = $urandom;
      stall = $urandom_range(0, 3) == 0;
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_target = 32'($urandom_range(0, 255));
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
